core_mem_lsu: RTL and testbench

- MEM stage of the student core, directly downstream of the EX-stage ALU.
- Consumes the ALU result as either a writeback value (non-memory ops) or an effective address (loads/stores).
- Drives a single-outstanding req/gnt/rvalid data-memory port and presents a registered result to WB.
- Formats load data: lane select and sign/zero extension. Generates store byte strobes.

---
 rtl/core_mem_lsu_pkg.sv | 18 +
 rtl/core_mem_lsu_fmt.sv | 62 ++++++
 rtl/core_mem_lsu.sv | 158 +++++++++++++++
 tb/tb_core_mem_lsu.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: datapath width,
// ex_size encodings and FSM state encoding.
package core_mem_lsu_pkg;

    localparam int CORE_XLEN = 32;

    // ex_size encodings; 2'b11 is handled as a word access
    localparam logic [1:0] CORE_LSU_SIZE_B = 2'b00;
    localparam logic [1:0] CORE_LSU_SIZE_H = 2'b01;
    localparam logic [1:0] CORE_LSU_SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/core_mem_lsu_fmt.sv
// Combinational lane logic for the LSU: store data replication and byte
// strobes on the issue side, lane extraction and sign/zero extension on the
// load-return side. Lane positions come from the low address bits, so a
// misaligned half/word is naturally force-aligned to its access size.
module core_mem_lsu_fmt
    import core_mem_lsu_pkg::*;
(
    input  logic [1:0]           st_size,
    input  logic [1:0]           st_addr_lo,
    input  logic [CORE_XLEN-1:0] st_data,
    output logic [CORE_XLEN-1:0] st_wdata,
    output logic [3:0]           st_wstrb,
    input  logic [1:0]           ld_size,
    input  logic [1:0]           ld_addr_lo,
    input  logic                 ld_unsigned,
    input  logic [CORE_XLEN-1:0] ld_rdata,
    output logic [CORE_XLEN-1:0] ld_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Store side: replicate the datum across every lane it may land in.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        st_wdata = st_data;
        st_wstrb = 4'b1111;
        case (st_size)
            CORE_LSU_SIZE_B: begin
                st_wdata = {4{st_data[7:0]}};
                st_wstrb = 4'b0001 << st_addr_lo;
            end
            CORE_LSU_SIZE_H: begin
                st_wdata = {2{st_data[15:0]}};
                st_wstrb = st_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = st_data;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Load side: pick the addressed lane, then extend it to a full word.
    always_comb begin
        byte_lane = ld_rdata[7:0];
        half_lane = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        ld_data   = ld_rdata;
        case (ld_addr_lo)
            2'd1:    byte_lane = ld_rdata[15:8];
            2'd2:    byte_lane = ld_rdata[23:16];
            2'd3:    byte_lane = ld_rdata[31:24];
            default: byte_lane = ld_rdata[7:0];
        endcase
        case (ld_size)
            CORE_LSU_SIZE_B: ld_data = {{24{byte_lane[7] & ~ld_unsigned}}, byte_lane};
            CORE_LSU_SIZE_H: ld_data = {{16{half_lane[15] & ~ld_unsigned}}, half_lane};
            default:         ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/core_mem_lsu.sv
// MEM stage of the student core. Passes ALU results straight to WB, or runs
// a single-outstanding req/gnt/rvalid data-memory access for loads/stores.
// Optional build macro CORE_LSU_MISALIGN_TRAP_EN: misaligned half/word
// accesses issue no request and retire as a misalign_err pulse carrying the
// faulting address; without it the low address bits are force-aligned.
module core_mem_lsu
    import core_mem_lsu_pkg::*;
#(
    parameter int XLEN   = CORE_XLEN,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [XLEN-1:0]   ex_result,
    input  logic [XLEN-1:0]   ex_store_data,
    input  logic              ex_is_load,
    input  logic              ex_is_store,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsigned,
    input  logic [4:0]        ex_rd,
    input  logic              ex_rd_wen,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic              wb_wen,
    output logic [XLEN-1:0]   wb_data,
    output logic              lsu_busy,
    output logic              misalign_err
);

    lsu_state_t      state;
    logic [1:0]      size_q;
    logic [1:0]      addr_lo_q;
    logic            unsigned_q;
    logic            is_store_q;
    logic [4:0]      rd_q;
    logic            wen_q;

    logic            accept;
    logic            is_mem;
    logic            misaligned;
    logic [XLEN-1:0] st_wdata;
    logic [3:0]      st_wstrb;
    logic [XLEN-1:0] ld_data;

    assign ex_ready = (state == ST_IDLE);
    assign lsu_busy = (state != ST_IDLE);
    assign accept   = ex_valid & ex_ready;
    assign is_mem   = ex_is_load | ex_is_store;

`ifdef CORE_LSU_MISALIGN_TRAP_EN
    assign misaligned = is_mem &&
                        (((ex_size == CORE_LSU_SIZE_H) && ex_result[0]) ||
                         ((ex_size[1] == 1'b1) && (ex_result[1:0] != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    core_mem_lsu_fmt u_fmt (
        .st_size     (ex_size),
        .st_addr_lo  (ex_result[1:0]),
        .st_data     (ex_store_data),
        .st_wdata    (st_wdata),
        .st_wstrb    (st_wstrb),
        .ld_size     (size_q),
        .ld_addr_lo  (addr_lo_q),
        .ld_unsigned (unsigned_q),
        .ld_rdata    (mem_rdata),
        .ld_data     (ld_data)
    );

    // Control FSM with registered memory-port and writeback outputs.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state        <= ST_IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= 4'b0000;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'd0;
            wb_wen       <= 1'b0;
            wb_data      <= '0;
            misalign_err <= 1'b0;
            size_q       <= CORE_LSU_SIZE_B;
            addr_lo_q    <= 2'b00;
            unsigned_q   <= 1'b0;
            is_store_q   <= 1'b0;
            rd_q         <= 5'd0;
            wen_q        <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            misalign_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (!is_mem || misaligned) begin
                            wb_valid     <= 1'b1;
                            wb_rd        <= ex_rd;
                            wb_wen       <= ex_rd_wen & ~misaligned;
                            wb_data      <= ex_result;
                            misalign_err <= misaligned;
                        end else begin
                            state      <= ST_REQ;
                            mem_req    <= 1'b1;
                            mem_we     <= ex_is_store;
                            mem_addr   <= {ex_result[ADDR_W-1:2], 2'b00};
                            mem_wdata  <= ex_is_store ? st_wdata : '0;
                            mem_wstrb  <= ex_is_store ? st_wstrb : 4'b0000;
                            size_q     <= ex_size;
                            addr_lo_q  <= ex_result[1:0];
                            unsigned_q <= ex_unsigned;
                            is_store_q <= ex_is_store;
                            rd_q       <= ex_rd;
                            wen_q      <= ex_rd_wen;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (is_store_q) begin
                            state    <= ST_IDLE;
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_q;
                            wb_wen   <= 1'b0;
                            wb_data  <= '0;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        state    <= ST_IDLE;
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        wb_wen   <= wen_q;
                        wb_data  <= ld_data;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_mem_lsu.sv
// Self-checking bench for core_mem_lsu: directed scenarios plus randomized
// operations against a byte-level behavioural model of the MEM stage.
module tb_core_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [1:0]  ex_size;
    logic        ex_unsigned;
    logic [4:0]  ex_rd;
    logic        ex_rd_wen;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_wen;
    logic [31:0] wb_data;
    logic        lsu_busy;
    logic        misalign_err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    core_mem_lsu dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
        .ex_store_data(ex_store_data), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data),
        .lsu_busy(lsu_busy), .misalign_err(misalign_err)
    );

    // ---------------- reference model ----------------
    function automatic int m_bytes(input logic [1:0] sz);
        if (sz == 2'd0) return 1;
        if (sz == 2'd1) return 2;
        return 4;
    endfunction

    function automatic int m_offset(input logic [1:0] sz, input logic [31:0] a);
        int lo;
        lo = int'(a % 4);
        return lo - (lo % m_bytes(sz));
    endfunction

    function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
        return (int'(a % 4) % m_bytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] m_strb(input logic [1:0] sz, input logic [31:0] a);
        return 4'(((1 << m_bytes(sz)) - 1) << m_offset(sz, a));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (m_bytes(sz) == 1) return (d & 32'h0000_00FF) * 32'h0101_0101;
        if (m_bytes(sz) == 2) return (d & 32'h0000_FFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a,
                                           input logic uns, input logic [31:0] rdata);
        longint v;
        longint span;
        if (m_bytes(sz) == 4) return rdata;
        span = longint'(1) << (8 * m_bytes(sz));
        v = (longint'(rdata) >> (8 * m_offset(sz, a))) % span;
        if (!uns && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic bit m_traps(input logic ld, input logic st, input logic [1:0] sz,
                                   input logic [31:0] a);
`ifdef CORE_LSU_MISALIGN_TRAP_EN
        return (ld || st) && m_misaligned(sz, a);
`else
        return 1'b0 && (ld || st || sz[0] || a[0]);
`endif
    endfunction

    // ---------------- generic operation driver ----------------
    // Called at a negedge with the unit idle; returns at a negedge with it idle.
    task automatic run_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] res, input logic [31:0] sdata, input logic [31:0] rdata,
                          input logic [4:0] rd, input logic wen, input int gnt_dly, input int rv_dly);
        bit trap;
        logic [31:0] exp_data;
        trap = m_traps(ld, st, sz, res);
        vectors++; if (ex_ready !== 1'b1) begin miscompares++; $display("FAIL op_ready: got %b want 1", ex_ready); end
        ex_valid = 1'b1; ex_result = res; ex_store_data = sdata; ex_is_load = ld; ex_is_store = st;
        ex_size = sz; ex_unsigned = uns; ex_rd = rd; ex_rd_wen = wen;
        @(negedge clk);
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
        ex_result = $urandom; ex_rd = 5'($urandom);
        if (!(ld || st) || trap) begin
            vectors++; if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL direct_wb_valid: got %b want 1", wb_valid); end
            vectors++; if (wb_data !== res) begin miscompares++; $display("FAIL direct_wb_data: got %h want %h", wb_data, res); end
            vectors++; if (wb_rd !== rd) begin miscompares++; $display("FAIL direct_wb_rd: got %0d want %0d", wb_rd, rd); end
            vectors++; if (wb_wen !== (wen & !trap)) begin miscompares++; $display("FAIL direct_wb_wen: got %b want %b", wb_wen, wen & !trap); end
            vectors++; if (misalign_err !== trap) begin miscompares++; $display("FAIL direct_misalign: got %b want %b", misalign_err, trap); end
            vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL direct_no_req: got %b want 0", mem_req); end
            @(negedge clk);
            vectors++; if ({wb_valid, misalign_err} !== 2'b00) begin miscompares++; $display("FAIL direct_pulse_end: got %b want 00", {wb_valid, misalign_err}); end
            return;
        end
        for (int i = 0; i <= gnt_dly; i++) begin
            vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL req_held: cycle %0d got %b want 1", i, mem_req); end
            vectors++; if (mem_we !== st) begin miscompares++; $display("FAIL req_we: got %b want %b", mem_we, st); end
            vectors++; if (mem_addr !== {res[31:2], 2'b00}) begin miscompares++; $display("FAIL req_addr: got %h want %h", mem_addr, {res[31:2], 2'b00}); end
            vectors++; if (mem_wstrb !== (st ? m_strb(sz, res) : 4'b0000)) begin miscompares++; $display("FAIL req_wstrb: got %b want %b", mem_wstrb, st ? m_strb(sz, res) : 4'b0000); end
            if (st) begin
                vectors++; if (mem_wdata !== m_wdata(sz, sdata)) begin miscompares++; $display("FAIL req_wdata: got %h want %h", mem_wdata, m_wdata(sz, sdata)); end
            end
            vectors++; if ({ex_ready, lsu_busy, wb_valid} !== 3'b010) begin miscompares++; $display("FAIL req_status: got %b want 010", {ex_ready, lsu_busy, wb_valid}); end
            mem_gnt = (i == gnt_dly);
            mem_rvalid = 1'($urandom);          // stray responses in REQ must be ignored
            mem_rdata = $urandom;
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
        end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL req_drop: got %b want 0", mem_req); end
        if (st) begin
            vectors++; if ({wb_valid, wb_wen} !== 2'b10) begin miscompares++; $display("FAIL store_wb: got %b want 10", {wb_valid, wb_wen}); end
            vectors++; if (ex_ready !== 1'b1) begin miscompares++; $display("FAIL store_idle: got %b want 1", ex_ready); end
            @(negedge clk);
            vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL store_pulse_end: got %b want 0", wb_valid); end
            return;
        end
        for (int i = 0; i <= rv_dly; i++) begin
            vectors++; if ({wb_valid, lsu_busy, ex_ready} !== 3'b010) begin miscompares++; $display("FAIL wait_status: got %b want 010", {wb_valid, lsu_busy, ex_ready}); end
            mem_rvalid = (i == rv_dly);
            mem_rdata = (i == rv_dly) ? rdata : $urandom;
            @(negedge clk);
            mem_rvalid = 1'b0; mem_rdata = $urandom;
        end
        exp_data = m_load(sz, res, uns, rdata);
        vectors++; if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL load_wb_valid: got %b want 1", wb_valid); end
        vectors++; if (wb_data !== exp_data) begin miscompares++; $display("FAIL load_wb_data: got %h want %h", wb_data, exp_data); end
        vectors++; if ({wb_rd, wb_wen} !== {rd, wen}) begin miscompares++; $display("FAIL load_wb_rd_wen: got %h want %h", {wb_rd, wb_wen}, {rd, wen}); end
        vectors++; if ({ex_ready, misalign_err} !== 2'b10) begin miscompares++; $display("FAIL load_idle: got %b want 10", {ex_ready, misalign_err}); end
        @(negedge clk);
        vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL load_pulse_end: got %b want 0", wb_valid); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; ex_valid = 1'b0; ex_result = '0; ex_store_data = '0; ex_is_load = 1'b0;
        ex_is_store = 1'b0; ex_size = 2'd0; ex_unsigned = 1'b0; ex_rd = '0; ex_rd_wen = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        vectors++; if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, wb_valid, wb_rd, wb_wen, wb_data, lsu_busy, misalign_err} !== '0) begin
            miscompares++; $display("FAIL reset_outputs: got %h want 0", {mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, wb_valid, wb_rd, wb_wen, wb_data, lsu_busy, misalign_err});
        end
        vectors++; if (ex_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", ex_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nonmem_burst();
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        ex_is_load = 1'b0; ex_is_store = 1'b0; ex_rd_wen = 1'b1;
        for (int i = 0; i <= 3; i++) begin
            if (i > 0) begin
                vectors++; if ({wb_valid, wb_data, wb_rd, wb_wen} !== {1'b1, vals[i-1], 5'(i + 3), 1'b1}) begin
                    miscompares++; $display("FAIL burst_wb: cycle %0d got %b/%h want 1/%h", i, wb_valid, wb_data, vals[i-1]);
                end
                vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL burst_no_req: got %b want 0", mem_req); end
            end
            if (i < 3) begin
                vectors++; if (ex_ready !== 1'b1) begin miscompares++; $display("FAIL burst_ready: got %b want 1", ex_ready); end
                ex_valid = 1'b1; ex_result = vals[i]; ex_rd = 5'(i + 4);
            end else begin
                ex_valid = 1'b0;
            end
            @(negedge clk);
        end
        vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL burst_end: got %b want 0", wb_valid); end
    endtask

    task automatic test_store_byte();
        run_op(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 5'd7, 1'b1, 3, 0);
        run_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_1006, 32'h1234_BEEF, 32'h0, 5'd8, 1'b1, 0, 0);
        run_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_1008, 32'hCAFE_F00D, 32'h0, 5'd9, 1'b1, 1, 0);
    endtask

    task automatic test_loads();
        run_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_2001, 32'h0, 32'h0000_8000, 5'd10, 1'b1, 0, 0);
        run_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_2001, 32'h0, 32'h0000_8000, 5'd11, 1'b1, 1, 2);
        run_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_0000, 5'd12, 1'b1, 0, 1);
        run_op(1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_2004, 32'h0, 32'hDEAD_BEEF, 5'd13, 1'b0, 2, 0);
    endtask

    task automatic test_misalign();
        run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_3002, 32'h0, 32'h89AB_CDEF, 5'd14, 1'b1, 0, 0);
        run_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_3005, 32'h0000_5A5A, 32'h0, 5'd15, 1'b1, 1, 0);
    endtask

    task automatic test_stray_and_reset();
        // stray responses while idle
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) begin
            @(negedge clk);
            vectors++; if ({wb_valid, lsu_busy} !== 2'b00) begin miscompares++; $display("FAIL idle_stray: got %b want 00", {wb_valid, lsu_busy}); end
        end
        mem_rvalid = 1'b0;
        // reset while the request is outstanding
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_size = 2'd2; ex_result = 32'h4000; ex_rd = 5'd3; ex_rd_wen = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0; ex_is_load = 1'b0;
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rst_req_setup: got %b want 1", mem_req); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if ({mem_req, ex_ready, lsu_busy, wb_valid} !== 4'b0100) begin miscompares++; $display("FAIL rst_in_req: got %b want 0100", {mem_req, ex_ready, lsu_busy, wb_valid}); end
        // reset in WAIT, stray rvalid the cycle after
        ex_valid = 1'b1; ex_is_load = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0; ex_is_load = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        vectors++; if ({lsu_busy, mem_req} !== 2'b10) begin miscompares++; $display("FAIL rst_wait_setup: got %b want 10", {lsu_busy, mem_req}); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        vectors++; if ({ex_ready, lsu_busy, wb_valid} !== 3'b100) begin miscompares++; $display("FAIL rst_in_wait: got %b want 100", {ex_ready, lsu_busy, wb_valid}); end
        @(negedge clk);
        mem_rvalid = 1'b0;
        repeat (2) begin
            vectors++; if ({wb_valid, ex_ready, lsu_busy} !== 3'b010) begin miscompares++; $display("FAIL rst_stray_ignored: got %b want 010", {wb_valid, ex_ready, lsu_busy}); end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int kind;
        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom_range(0, 2));
            run_op(kind == 1, kind == 2, 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom,
                   $urandom, 5'($urandom), 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nonmem_burst();
        test_store_byte();
        test_loads();
        test_misalign();
        test_stray_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
